// File: rtl/nbr64_ctrl_if.sv
// Request/response handshake and NBR64 macro pins of the evaluation controller.
// The master side is the front end plus the macro model; the slave side is nbr64_ctrl.
interface nbr64_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_chal;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_bit;
  logic [CNT_W-1:0] rsp_ones;
  logic             busy;
  logic [63:0]      puf_c;
  logic             puf_reset;
  logic             puf_out;

  modport master (
    output req_valid, req_chal, rsp_ready, puf_out,
    input  req_ready, rsp_valid, rsp_bit, rsp_ones, busy, puf_c, puf_reset
  );

  modport slave (
    input  req_valid, req_chal, rsp_ready, puf_out,
    output req_ready, rsp_valid, rsp_bit, rsp_ones, busy, puf_c, puf_reset
  );
endinterface

// File: rtl/nbr64_ctrl.sv
// NBR64 bistable-ring PUF evaluation controller: runs NEVAL reset/settle/sample
// evaluations per accepted challenge and returns a majority-voted bit plus ones-count.
module nbr64_ctrl #(
  parameter  int NEVAL      = 5,
  parameter  int RESET_CYC  = 4,
  parameter  int SETTLE_CYC = 16,
  localparam int CNT_W      = $clog2(NEVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  nbr64_ctrl_if.slave  bus
);

  localparam int PH_RAW = ($clog2(RESET_CYC) > $clog2(SETTLE_CYC)) ?
                          $clog2(RESET_CYC) : $clog2(SETTLE_CYC);
  localparam int PH_W   = (PH_RAW < 1) ? 1 : PH_RAW;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] eval_q, eval_d;
  logic [63:0]      chal_q, chal_d;
  logic             puf_reset_q, puf_reset_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_bit_q, rsp_bit_d;
  logic [CNT_W-1:0] rsp_ones_q, rsp_ones_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] ones_inc_s;

  // Next-state and next-output computation for the evaluation sequencer
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ones_d      = ones_q;
    eval_d      = eval_q;
    chal_d      = chal_q;
    puf_reset_d = puf_reset_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bit_d   = rsp_bit_q;
    rsp_ones_d  = rsp_ones_q;
    sync1_d     = bus.puf_out;
    sync2_d     = sync1_q;
    // Only the synchronized macro output ever feeds the vote
    ones_inc_s  = ones_q + CNT_W'(sync2_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          chal_d      = bus.req_chal;
          ones_d      = '0;
          eval_d      = '0;
          phase_d     = '0;
          puf_reset_d = 1'b1;
          state_d     = ST_RST;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_RST: begin
        if (phase_q == PH_W'(RESET_CYC - 1)) begin
          phase_d     = '0;
          puf_reset_d = 1'b0;
          state_d     = ST_SETTLE;
        end else begin
          phase_d     = phase_q + PH_W'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
          phase_d = '0;
          state_d = ST_SAMPLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_SAMPLE: begin
        ones_d = ones_inc_s;
        eval_d = eval_q + CNT_W'(1);
        if (eval_q == CNT_W'(NEVAL - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_ones_d  = ones_inc_s;
          // NEVAL is odd, so a strict majority always exists
          rsp_bit_d   = (ones_inc_s > CNT_W'(NEVAL / 2));
          state_d     = ST_DONE;
        end else begin
          puf_reset_d = 1'b1;
          state_d     = ST_RST;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        puf_reset_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      ones_q      <= '0;
      eval_q      <= '0;
      chal_q      <= 64'd0;
      puf_reset_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_ones_q  <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ones_q      <= ones_d;
      eval_q      <= eval_d;
      chal_q      <= chal_d;
      puf_reset_q <= puf_reset_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_ones_q  <= rsp_ones_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.puf_c     = chal_q;
  assign bus.puf_reset = puf_reset_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign bus.rsp_ones  = rsp_ones_q;

endmodule

// File: tb/tb_nbr64_ctrl.sv
// Randomized bench for nbr64_ctrl: a default instance (NEVAL=5, P=21) and a corner
// instance (NEVAL=1, RESET_CYC=1, SETTLE_CYC=3), both checked every cycle against a timing model.
module tb_nbr64_ctrl;

  localparam int NE0 = 5, R0 = 4, S0 = 16;
  localparam int NE1 = 1, R1 = 1, S1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nbr64_ctrl_if #(.CNT_W(3)) bus0 ();
  nbr64_ctrl_if #(.CNT_W(1)) bus1 ();

  nbr64_ctrl #(.NEVAL(NE0), .RESET_CYC(R0), .SETTLE_CYC(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  nbr64_ctrl #(.NEVAL(NE1), .RESET_CYC(R1), .SETTLE_CYC(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic        req_valid_i [2];
  logic [63:0] req_chal_i  [2];
  logic        rsp_ready_i [2];
  logic        puf_out_i   [2];
  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic        rsp_bit_o   [2];
  logic        busy_o      [2];
  logic        puf_reset_o [2];
  logic [63:0] puf_c_o     [2];
  logic [7:0]  ones_o      [2];

  assign bus0.req_valid = req_valid_i[0];
  assign bus0.req_chal  = req_chal_i[0];
  assign bus0.rsp_ready = rsp_ready_i[0];
  assign bus0.puf_out   = puf_out_i[0];
  assign bus1.req_valid = req_valid_i[1];
  assign bus1.req_chal  = req_chal_i[1];
  assign bus1.rsp_ready = rsp_ready_i[1];
  assign bus1.puf_out   = puf_out_i[1];
  assign req_ready_o[0] = bus0.req_ready;
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_bit_o[0]   = bus0.rsp_bit;
  assign rsp_bit_o[1]   = bus1.rsp_bit;
  assign busy_o[0]      = bus0.busy;
  assign busy_o[1]      = bus1.busy;
  assign puf_reset_o[0] = bus0.puf_reset;
  assign puf_reset_o[1] = bus1.puf_reset;
  assign puf_c_o[0]     = bus0.puf_c;
  assign puf_c_o[1]     = bus1.puf_c;
  assign ones_o[0]      = 8'(bus0.rsp_ones);
  assign ones_o[1]      = 8'(bus1.rsp_ones);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit [7:0] pbits [2];   // bit k = value the macro settles to in evaluation k

  function automatic int ne_of(input int i); return (i == 0) ? NE0 : NE1; endfunction
  function automatic int r_of(input int i);  return (i == 0) ? R0 : R1;   endfunction
  function automatic int s_of(input int i);  return (i == 0) ? S0 : S1;   endfunction
  // Hand-computed: 1 + NEVAL*P, pulse count, total PUF_RESET high cycles
  function automatic int exp_lat(input int i);    return (i == 0) ? 106 : 6; endfunction
  function automatic int exp_pulses(input int i); return (i == 0) ? 5 : 1;   endfunction
  function automatic int exp_high(input int i);   return (i == 0) ? 20 : 1;  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Macro model: garbage while RESET is high, then settles to the evaluation's bit
  int pk [2];
  bit prev_pr [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!busy_o[i]) begin
        pk[i] = 0;
        prev_pr[i] = 1'b0;
      end else if (puf_reset_o[i]) begin
        puf_out_i[i] = 1'($urandom_range(0, 1));
        prev_pr[i] = 1'b1;
      end else if (prev_pr[i]) begin
        puf_out_i[i] = pbits[i][pk[i]];
        pk[i] = pk[i] + 1;
        prev_pr[i] = 1'b0;
      end
    end
  end

  // Behavioural model: a run is characterised by its accept cycle only
  bit          m_busy [2];
  int          m_t    [2];
  logic [63:0] m_chal [2];
  logic [7:0]  m_ones [2];
  logic        m_bit  [2];
  always @(posedge clk) begin : model_cmp
    int ne, p, d;
    bit [7:0] mask;
    bit e_rv, e_pr;
    for (int i = 0; i < 2; i++) begin
      ne = ne_of(i);
      p  = r_of(i) + s_of(i) + 1;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_chal[i] = 64'd0; m_ones[i] = 8'd0; m_bit[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (req_valid_i[i]) begin
          m_busy[i] = 1'b1; m_t[i] = cyc; m_chal[i] = req_chal_i[i];
        end
      end else if ((cyc - m_t[i]) > ne * p && rsp_ready_i[i]) begin
        m_busy[i] = 1'b0;
      end
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ne = ne_of(i);
      p  = r_of(i) + s_of(i) + 1;
      if (m_busy[i] && (cyc - m_t[i]) == ne * p + 1) begin
        mask = 8'((1 << ne) - 1);
        m_ones[i] = 8'($countones(pbits[i] & mask));
        m_bit[i]  = (int'(m_ones[i]) > ne / 2);
      end
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      ne = ne_of(i);
      p  = r_of(i) + s_of(i) + 1;
      d  = cyc - m_t[i];
      e_rv = m_busy[i] && (d > ne * p);
      e_pr = m_busy[i] && (d >= 1) && (d <= ne * p) && (((d - 1) % p) < r_of(i));
      chk("req_ready", req_ready_o[i], !m_busy[i]);
      chk("busy", busy_o[i], m_busy[i]);
      chk("rsp_valid", rsp_valid_o[i], e_rv);
      chk("puf_reset", puf_reset_o[i], e_pr);
      chk("puf_c", puf_c_o[i], m_chal[i]);
      chk("rsp_ones", ones_o[i], m_ones[i]);
      chk("rsp_bit", rsp_bit_o[i], m_bit[i]);
    end
  end

  task automatic issue(input int idx, input logic [63:0] chal, input bit [7:0] bits,
                       output int t);
    int n = 0;
    @(negedge clk);
    pbits[idx] = bits;
    req_chal_i[idx] = chal;
    req_valid_i[idx] = 1'b1;
    while (!req_ready_o[idx] && n < 400) begin @(negedge clk); n++; end
    chk("accept_wait", req_ready_o[idx], 1'b1);
    t = cyc;
    @(negedge clk);
    req_valid_i[idx] = 1'b0;
    chk("puf_c_at_t1", puf_c_o[idx], chal);
  endtask

  task automatic wait_rsp(input int idx, input int t);
    int n = 0, pulses = 0, high = 0;
    bit prev = 1'b0;
    while (!rsp_valid_o[idx] && n < 400) begin
      if (puf_reset_o[idx] && !prev) pulses++;
      if (puf_reset_o[idx]) high++;
      prev = puf_reset_o[idx];
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", cyc - t, exp_lat(idx));
    chk("reset_pulses", pulses, exp_pulses(idx));
    chk("reset_high_cycles", high, exp_high(idx));
  endtask

  task automatic ack(input int idx, input int delay);
    repeat (delay) @(negedge clk);
    rsp_ready_i[idx] = 1'b1;
    @(negedge clk);
    rsp_ready_i[idx] = 1'b0;
  endtask

  initial begin : stim
    int t, t2, h;
    bit [7:0] b;
    logic [63:0] ca, cb;
    for (int i = 0; i < 2; i++) begin
      req_valid_i[i] = 1'b0; req_chal_i[i] = 64'd0; rsp_ready_i[i] = 1'b0; pbits[i] = 8'd0;
    end
    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_req_ready", req_ready_o[0], 1'b1);
    chk("idle_puf_c", puf_c_o[0], 64'd0);
    chk("idle_puf_reset", puf_reset_o[0], 1'b0);

    // Nominal: every sample reads 1
    issue(0, 64'hDEADBEEF_0123ABCD, 8'h1F, t);
    wait_rsp(0, t);
    ack(0, 0);
    chk("nominal_ones", ones_o[0], 8'd5);
    chk("nominal_bit", rsp_bit_o[0], 1'b1);

    // Majority patterns 1,0,1,0,0 and 0,1,1,0,1
    issue(0, 64'h1111_2222_3333_4444, 8'b00101, t);
    wait_rsp(0, t);
    ack(0, 2);
    chk("maj_a_ones", ones_o[0], 8'd2);
    chk("maj_a_bit", rsp_bit_o[0], 1'b0);
    issue(0, 64'h5555_6666_7777_8888, 8'b10110, t);
    wait_rsp(0, t);
    ack(0, 1);
    chk("maj_b_ones", ones_o[0], 8'd3);
    chk("maj_b_bit", rsp_bit_o[0], 1'b1);

    // Backpressure with a new request held during DONE
    ca = 64'hA5A5_0000_FFFF_1234;
    cb = 64'h0F0F_8888_4321_CAFE;
    issue(0, ca, 8'b01011, t);
    wait_rsp(0, t);
    req_chal_i[0] = cb;
    req_valid_i[0] = 1'b1;
    repeat (10) begin
      chk("bp_req_ready", req_ready_o[0], 1'b0);
      chk("bp_puf_c", puf_c_o[0], ca);
      chk("bp_rsp_valid", rsp_valid_o[0], 1'b1);
      chk("bp_ones", ones_o[0], 8'd3);
      @(negedge clk);
    end
    pbits[0] = 8'b11001;
    rsp_ready_i[0] = 1'b1;
    h = cyc;
    @(negedge clk);
    rsp_ready_i[0] = 1'b0;
    chk("bp_idle_ready", req_ready_o[0], 1'b1);
    t2 = cyc;
    chk("bp_accept_gap", t2 - h, 1);
    @(negedge clk);
    req_valid_i[0] = 1'b0;
    chk("bp_new_chal", puf_c_o[0], cb);
    wait_rsp(0, t2);
    ack(0, 0);
    chk("bp2_ones", ones_o[0], 8'd3);

    // Reset during SETTLE of evaluation 2, then re-issue
    issue(0, 64'hC0DE_C0DE_1357_9BDF, 8'h1F, t);
    while (cyc < t + 51 && cyc < t + 400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_puf_reset", puf_reset_o[0], 1'b0);
    chk("abort_busy", busy_o[0], 1'b0);
    chk("abort_req_ready", req_ready_o[0], 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 64'hC0DE_C0DE_1357_9BDF, 8'b11011, t);
    wait_rsp(0, t);
    ack(0, 0);
    chk("rerun_ones", ones_o[0], 8'd4);
    chk("rerun_bit", rsp_bit_o[0], 1'b1);

    // Randomized runs on the default instance
    for (int n = 0; n < 8; n++) begin
      issue(0, {$urandom, $urandom}, 8'($urandom_range(0, 31)), t);
      wait_rsp(0, t);
      ack(0, $urandom_range(0, 4));
    end

    // Corner instance: NEVAL=1, RESET_CYC=1, SETTLE_CYC=3
    for (int n = 0; n < 8; n++) begin
      b = (n < 2) ? 8'(n) : 8'($urandom_range(0, 1));
      issue(1, {$urandom, $urandom}, b, t);
      wait_rsp(1, t);
      chk("corner_bit", rsp_bit_o[1], b[0]);
      ack(1, $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nbr64_ctrl.md
# nbr64_ctrl

Evaluation controller for the NBR64 bistable-ring PUF macro. It accepts a 64-bit challenge over a valid/ready handshake and drives it onto the macro. It then runs NEVAL reset/settle/sample evaluations and returns a majority-voted response bit plus the raw ones-count. It sits between the chip's register/scan front end and the hard NBR64 instance, and is the only driver of the macro's C and RESET pins.

## Interface

- NEVAL, 5: evaluations per challenge; odd, 1..255.
- RESET_CYC, 4: cycles PUF_RESET is held high per evaluation; >=1.
- SETTLE_CYC, 16: cycles PUF_RESET is held low before sampling; >=3, to cover the synchronizer.
- CNT_W, $clog2(NEVAL+1): width of the ones-count (derived; not overridden).

- CLK  in  1  single clock; all flops are rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  challenge request.
- REQ_READY  out  1  controller can accept a challenge.
- REQ_CHAL  in  64  challenge; sampled on handshake.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer accepts response.
- RSP_BIT  out  1  majority response.
- RSP_ONES  out  CNT_W  number of evaluations that sampled 1.
- BUSY  out  1  high in any state other than IDLE.
- PUF_C  out  64  challenge to the macro's C port.
- PUF_RESET  out  1  drives the macro's RESET pin; registered, glitch-free.
- PUF_OUT  in  1  macro OUT; asynchronous to CLK.

## Operation

- PUF_OUT passes through a 2-flop synchronizer (PUF_OUT_S). No logic uses raw PUF_OUT.
- FSM states:
  - IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY, latch REQ_CHAL into PUF_C, clear ones/eval counters, clear the phase counter, go to RST.
  - RST: PUF_RESET=1. After RESET_CYC cycles, go to SETTLE.
  - SETTLE: PUF_RESET=0. After SETTLE_CYC cycles, go to SAMPLE.
  - SAMPLE: one cycle. Add PUF_OUT_S to the ones counter and increment the eval counter. If the eval counter now equals NEVAL, go to DONE; otherwise go to RST.
  - DONE: RSP_VALID=1. RSP_BIT and RSP_ONES are stable. On RSP_READY, go to IDLE.
- Response rule: RSP_BIT = (RSP_ONES > NEVAL/2), with integer division. Because NEVAL is odd, there is never a tie.
- PUF_C holds the latched challenge from the accept cycle until the next accepted request. It does not change during evaluation or in DONE.
- REQ_READY is 0 in every state except IDLE. Requests presented while busy are not accepted; REQ_VALID may stay high.
- RSP_ONES and RSP_BIT are valid only while RSP_VALID=1. Outside that window they hold their last value.
- Counters are sized so they cannot wrap:
  - The ones counter saturates by construction at NEVAL.
  - The phase counter width is max($clog2(RESET_CYC), $clog2(SETTLE_CYC)), with at least 1 bit.

## Timing

- Reset values: REQ_READY=1 after reset release (combinational from IDLE). RSP_VALID=0, RSP_BIT=0, RSP_ONES=0, BUSY=0, PUF_C=0, PUF_RESET=0. Synchronizer flops are 0. State is IDLE.
- Assertion of RST_N forces all of the above immediately, including mid-evaluation. PUF_RESET drops asynchronously. No response is produced for the aborted challenge.
- Request accepted on cycle t:
  - PUF_C is valid and PUF_RESET=1 from cycle t+1.
  - Evaluation period P = RESET_CYC+SETTLE_CYC+1.
  - Evaluation k (0-based):
    - PUF_RESET is high in cycles t+1+kP .. t+kP+RESET_CYC.
    - PUF_RESET is low through the SAMPLE cycle t+(k+1)P.
  - RSP_VALID rises at cycle t+1+NEVAL*P.
- A sample reflects PUF_OUT as it was at least 2 cycles before the SAMPLE cycle.
- DONE lasts at least 1 cycle. If RSP_READY is already high, RSP_VALID is high for exactly 1 cycle.
- The earliest next accept is the cycle after the response handshake (IDLE for 1 cycle). There is no back-to-back overlap.
- PUF_RESET and RSP_* come from flops; REQ_READY and BUSY decode the state register.

## Test plan

- Reset/idle:
  - Stimulus: hold RST_N=0 for 3 cycles, release.
  - Required: all outputs at their reset values, REQ_READY=1, PUF_RESET never pulses with no request.
- Nominal (defaults, P=21):
  - Stimulus: accept REQ_CHAL=64'hDEADBEEF_0123ABCD at t; PUF model drives OUT=1 on every sample.
  - Required: PUF_C matches from t+1; 5 PUF_RESET pulses of 4 cycles each; RSP_VALID at t+106 with RSP_ONES=5 and RSP_BIT=1.
- Majority:
  - Stimulus: model returns 1,0,1,0,0 across the 5 evaluations.
  - Required: RSP_ONES=2, RSP_BIT=0.
  - Stimulus: model returns 0,1,1,0,1.
  - Required: RSP_ONES=3, RSP_BIT=1.
- Backpressure:
  - Stimulus: RSP_READY=0 for 10 cycles after RSP_VALID; REQ_VALID held high with a new challenge.
  - Required: RSP_* stable; REQ_READY=0 and PUF_C unchanged until the handshake. The new challenge is accepted exactly 1 cycle after the handshake.
- Mid-operation reset:
  - Stimulus: pull RST_N low during the SETTLE of evaluation 2, then re-issue the challenge.
  - Required: PUF_RESET=0 and state IDLE immediately; the new run reports counts from zero (RSP_ONES ≤ 5) with correct timing.
- Parameter corner:
  - Stimulus: NEVAL=1, RESET_CYC=1, SETTLE_CYC=3.
  - Required: RSP_VALID at t+6; RSP_BIT equals the synchronized OUT; PUF_RESET pulse is exactly 1 cycle.
